// File: rtl/matmul_ctrl_if.sv
// Control/status bundle between the register file, the matmul sequencer and the datapath.
// The slave modport is the sequencer side; the master modport is the driving side.
interface matmul_ctrl_if #(
    parameter int MAX_DIM     = 4,
    parameter int SP_NTARGETS = 4,
    parameter int DIM_W       = $clog2(MAX_DIM),
    parameter int SP_W        = $clog2(SP_NTARGETS)
);
    logic             start_i;
    logic [DIM_W-1:0] dim_n_i;
    logic [DIM_W-1:0] dim_k_i;
    logic [DIM_W-1:0] dim_m_i;
    logic             mode_bias_i;
    logic [SP_W-1:0]  read_target_i;
    logic [SP_W-1:0]  write_target_i;
    logic             ovf_i;

    logic             busy_o;
    logic             acc_clr_o;
    logic             acc_load_o;
    logic             sp_rd_en_o;
    logic [SP_W-1:0]  sp_rd_sel_o;
    logic             array_en_o;
    logic             feed_en_o;
    logic [DIM_W-1:0] feed_idx_o;
    logic             sp_we_o;
    logic [SP_W-1:0]  sp_wr_sel_o;
    logic             done_o;
    logic             start_clr_o;
    logic             ovf_o;

    modport slave (
        input  start_i, dim_n_i, dim_k_i, dim_m_i, mode_bias_i,
               read_target_i, write_target_i, ovf_i,
        output busy_o, acc_clr_o, acc_load_o, sp_rd_en_o, sp_rd_sel_o,
               array_en_o, feed_en_o, feed_idx_o, sp_we_o, sp_wr_sel_o,
               done_o, start_clr_o, ovf_o
    );

    modport master (
        output start_i, dim_n_i, dim_k_i, dim_m_i, mode_bias_i,
               read_target_i, write_target_i, ovf_i,
        input  busy_o, acc_clr_o, acc_load_o, sp_rd_en_o, sp_rd_sel_o,
               array_en_o, feed_en_o, feed_idx_o, sp_we_o, sp_wr_sel_o,
               done_o, start_clr_o, ovf_o
    );
endinterface

// File: rtl/matmul_ctrl.sv
// Matmul sequencer: clear/load, feed, drain and writeback phases, then done and
// start-bit clear. All outputs are registered alongside the state they belong to.
module matmul_ctrl #(
    parameter int MAX_DIM     = 4,
    parameter int SP_NTARGETS = 4,
    parameter int DIM_W       = $clog2(MAX_DIM),
    parameter int SP_W        = $clog2(SP_NTARGETS)
) (
    input logic         clk_i,
    input logic         rst_ni,
    matmul_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_WRITE, S_DONE
    } state_e;

    state_e           state_q;
    logic             start_q;
    logic [DIM_W-1:0] n_q, k_q, m_q;
    logic             bias_q;
    logic [SP_W-1:0]  rt_q, wt_q;
    logic [DIM_W-1:0] feed_cnt_q;
    logic [DIM_W:0]   drn_cnt_q;

    logic             busy_q, acc_clr_q, acc_load_q, sp_rd_en_q, array_en_q;
    logic             feed_en_q, sp_we_q, done_q, start_clr_q, ovf_q;
    logic [SP_W-1:0]  sp_rd_sel_q, sp_wr_sel_q;
    logic [DIM_W-1:0] feed_idx_q;

    logic             accept;
    logic [DIM_W:0]   drn_last;

    assign accept   = (state_q == S_IDLE) && bus.start_i && !start_q;
    // Encoded N-1 plus encoded M-1 is N+M-2, the final drain count.
    assign drn_last = {1'b0, n_q} + {1'b0, m_q};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            start_q     <= 1'b0;
            n_q         <= '0;
            k_q         <= '0;
            m_q         <= '0;
            bias_q      <= 1'b0;
            rt_q        <= '0;
            wt_q        <= '0;
            feed_cnt_q  <= '0;
            drn_cnt_q   <= '0;
            busy_q      <= 1'b0;
            acc_clr_q   <= 1'b0;
            acc_load_q  <= 1'b0;
            sp_rd_en_q  <= 1'b0;
            sp_rd_sel_q <= '0;
            array_en_q  <= 1'b0;
            feed_en_q   <= 1'b0;
            feed_idx_q  <= '0;
            sp_we_q     <= 1'b0;
            sp_wr_sel_q <= '0;
            done_q      <= 1'b0;
            start_clr_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            start_q <= bus.start_i;
            if (array_en_q && bus.ovf_i) ovf_q <= 1'b1;

            unique case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        state_q     <= S_CLEAR;
                        n_q         <= bus.dim_n_i;
                        k_q         <= bus.dim_k_i;
                        m_q         <= bus.dim_m_i;
                        bias_q      <= bus.mode_bias_i;
                        rt_q        <= bus.read_target_i;
                        wt_q        <= bus.write_target_i;
                        ovf_q       <= 1'b0;
                        busy_q      <= 1'b1;
                        acc_clr_q   <= !bus.mode_bias_i;
                        acc_load_q  <= bus.mode_bias_i;
                        sp_rd_en_q  <= bus.mode_bias_i;
                        sp_rd_sel_q <= bus.mode_bias_i ? bus.read_target_i : '0;
                    end
                end
                S_CLEAR: begin
                    state_q     <= S_FEED;
                    acc_clr_q   <= 1'b0;
                    acc_load_q  <= 1'b0;
                    sp_rd_en_q  <= 1'b0;
                    sp_rd_sel_q <= '0;
                    array_en_q  <= 1'b1;
                    feed_en_q   <= 1'b1;
                    feed_idx_q  <= '0;
                    feed_cnt_q  <= '0;
                end
                S_FEED: begin
                    if (feed_cnt_q == k_q) begin
                        state_q    <= S_DRAIN;
                        feed_en_q  <= 1'b0;
                        feed_idx_q <= '0;
                        drn_cnt_q  <= '0;
                    end else begin
                        feed_cnt_q <= feed_cnt_q + DIM_W'(1);
                        feed_idx_q <= feed_cnt_q + DIM_W'(1);
                    end
                end
                S_DRAIN: begin
                    if (drn_cnt_q == drn_last) begin
                        state_q     <= S_WRITE;
                        array_en_q  <= 1'b0;
                        sp_we_q     <= 1'b1;
                        sp_wr_sel_q <= wt_q;
                    end else begin
                        drn_cnt_q <= drn_cnt_q + (DIM_W+1)'(1);
                    end
                end
                S_WRITE: begin
                    state_q     <= S_DONE;
                    sp_we_q     <= 1'b0;
                    sp_wr_sel_q <= '0;
                    done_q      <= 1'b1;
                    start_clr_q <= 1'b1;
                end
                S_DONE: begin
                    state_q     <= S_IDLE;
                    done_q      <= 1'b0;
                    start_clr_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.busy_o      = busy_q;
    assign bus.acc_clr_o   = acc_clr_q;
    assign bus.acc_load_o  = acc_load_q;
    assign bus.sp_rd_en_o  = sp_rd_en_q;
    assign bus.sp_rd_sel_o = sp_rd_sel_q;
    assign bus.array_en_o  = array_en_q;
    assign bus.feed_en_o   = feed_en_q;
    assign bus.feed_idx_o  = feed_idx_q;
    assign bus.sp_we_o     = sp_we_q;
    assign bus.sp_wr_sel_o = sp_wr_sel_q;
    assign bus.done_o      = done_q;
    assign bus.start_clr_o = start_clr_q;
    assign bus.ovf_o       = ovf_q;
endmodule

// File: tb/tb_matmul_ctrl.sv
// Directed bench for matmul_ctrl: per-operation phase counts, selects, timing,
// start-edge handling, async reset abort and overflow stickiness.
module tb_matmul_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    matmul_ctrl_if #(.MAX_DIM(4), .SP_NTARGETS(4)) bus ();

    matmul_ctrl #(.MAX_DIM(4), .SP_NTARGETS(4)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [9:0] all_outs();
        return {bus.busy_o, bus.acc_clr_o, bus.acc_load_o, bus.sp_rd_en_o, bus.array_en_o,
                bus.feed_en_o, bus.sp_we_o, bus.done_o, bus.start_clr_o, bus.ovf_o};
    endfunction

    // Raises start_i (leaving it high) and observes a 20-cycle window after the accepting edge.
    task automatic run_op(input string name,
                          input logic [1:0] dn, input logic [1:0] dk, input logic [1:0] dm,
                          input logic bias, input logic [1:0] rt, input logic [1:0] wt,
                          input int chg_cyc, input int ovf_cyc,
                          input int e_clr, input int e_load, input int e_rdsel,
                          input int e_feed, input int e_arr, input int e_wrsel,
                          input int e_done, input int e_ovf);
        int n_clr = 0, n_load = 0, rdsel = 0, n_feed = 0, n_arr = 0, n_we = 0, wrsel = -1;
        int done_c = 0, sclr_c = 0, n_busy = 0, first_ctl = 0, first_feed = 0;
        int bad_idx = 0, sel_bad = 0, ovf_at_done = -1;
        @(negedge clk);
        bus.dim_n_i = dn; bus.dim_k_i = dk; bus.dim_m_i = dm;
        bus.mode_bias_i = bias; bus.read_target_i = rt; bus.write_target_i = wt;
        bus.start_i = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (bus.acc_clr_o) n_clr++;
            if (bus.acc_load_o) n_load++;
            if ((bus.acc_clr_o || bus.acc_load_o) && first_ctl == 0) first_ctl = c;
            if (bus.sp_rd_en_o) rdsel = int'(bus.sp_rd_sel_o);
            if (bus.feed_en_o) begin
                if (first_feed == 0) first_feed = c;
                if (int'(bus.feed_idx_o) != n_feed) bad_idx++;
                n_feed++;
            end
            if (bus.array_en_o) n_arr++;
            if (bus.sp_we_o) begin n_we++; wrsel = int'(bus.sp_wr_sel_o); end
            if (bus.done_o) begin done_c = c; ovf_at_done = int'(bus.ovf_o); end
            if (bus.start_clr_o) sclr_c = c;
            if (bus.busy_o) n_busy++;
            if ((!bus.sp_rd_en_o && bus.sp_rd_sel_o != 0) || (!bus.sp_we_o && bus.sp_wr_sel_o != 0) ||
                (!bus.feed_en_o && bus.feed_idx_o != 0)) sel_bad++;
            if (c == chg_cyc) begin
                bus.dim_n_i = 2'd3; bus.dim_k_i = 2'd3; bus.dim_m_i = 2'd3;
                bus.read_target_i = 2'd0; bus.write_target_i = 2'd0;
            end
            bus.ovf_i = (c == ovf_cyc);
        end
        bus.ovf_i = 1'b0;
        check({name, ".acc_clr"},    n_clr,      e_clr);
        check({name, ".acc_load"},   n_load,     e_load);
        check({name, ".ctl_cycle"},  first_ctl,  1);
        check({name, ".rd_sel"},     rdsel,      e_rdsel);
        check({name, ".feed_cyc"},   n_feed,     e_feed);
        check({name, ".feed_start"}, first_feed, 2);
        check({name, ".feed_idx"},   bad_idx,    0);
        check({name, ".array_en"},   n_arr,      e_arr);
        check({name, ".sp_we"},      n_we,       1);
        check({name, ".wr_sel"},     wrsel,      e_wrsel);
        check({name, ".done_cyc"},   done_c,     e_done);
        check({name, ".sclr_cyc"},   sclr_c,     e_done);
        check({name, ".busy_cyc"},   n_busy,     e_done);
        check({name, ".sel_zero"},   sel_bad,    0);
        check({name, ".ovf"},        ovf_at_done, e_ovf);
    endtask

    task automatic drop_start();
        @(negedge clk); bus.start_i = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int n;
        bus.start_i = 1'b0; bus.dim_n_i = '0; bus.dim_k_i = '0; bus.dim_m_i = '0;
        bus.mode_bias_i = 1'b0; bus.read_target_i = '0; bus.write_target_i = '0;
        bus.ovf_i = 1'b0;
        #22 rst_n = 1'b1;
        @(posedge clk); #1;
        check("reset.outs", int'(all_outs()), 0);

        // 4x4x4, clear mode
        run_op("opA", 2'd3, 2'd3, 2'd3, 1'b0, 2'd0, 2'd3, 0, 0,
               1, 0, 0, 4, 11, 3, 14, 0);
        drop_start();

        // 1x1x1, bias from slot 2 into slot 1; start stays high afterwards
        run_op("opB", 2'd0, 2'd0, 2'd0, 1'b1, 2'd2, 2'd1, 0, 0,
               0, 1, 2, 1, 2, 1, 5, 0);
        n = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (bus.busy_o) n++;
        end
        check("held_start.busy", n, 0);
        drop_start();

        // N=2 K=3 M=1, inputs altered in FEED, ovf pulse in the last DRAIN cycle
        run_op("opC", 2'd1, 2'd2, 2'd0, 1'b1, 2'd3, 2'd2, 3, 6,
               0, 1, 3, 3, 5, 2, 8, 1);
        drop_start();
        bus.ovf_i = 1'b1;
        @(posedge clk); #1;
        bus.ovf_i = 1'b0;
        check("idle_ovf.sticky", int'(bus.ovf_o), 1);

        // N=3 K=1 M=4, fresh accept clears the sticky overflow
        run_op("opD", 2'd2, 2'd0, 2'd3, 1'b0, 2'd1, 2'd0, 0, 0,
               1, 0, 0, 1, 7, 0, 10, 0);
        drop_start();

        // Async reset in the third FEED cycle
        bus.dim_n_i = 2'd3; bus.dim_k_i = 2'd3; bus.dim_m_i = 2'd3;
        bus.mode_bias_i = 1'b0; bus.write_target_i = 2'd2;
        bus.start_i = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk); #1;
        end
        check("pre_rst.feed", int'(bus.feed_en_o), 1);
        rst_n = 1'b0;
        bus.start_i = 1'b0;
        #1;
        check("rst_async.outs", int'(all_outs()), 0);
        n = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (all_outs() != 0) n++;
        end
        @(negedge clk); rst_n = 1'b1;
        repeat (12) begin
            @(posedge clk); #1;
            if (bus.busy_o || bus.sp_we_o || bus.done_o) n++;
        end
        check("rst_abort.idle", n, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        failures++;
        $display("FAIL timeout: got 0 expected 1");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end
endmodule

// File: doc/matmul_ctrl.md
Name: matmul_ctrl

Overview:
Sequencing FSM for the matmul accelerator datapath (systolic PE array, accumulators, scratchpad). Triggered by the start bit of the control register. Latches the operation configuration: dimensions, bias mode and scratchpad targets. Drives the clear/load, feed, drain and writeback phases, then pulses done and requests start-bit clearing from the register file.

Parameters:
MAX_DIM, 4, maximum matrix dimension (N, K, M each 1..MAX_DIM)
SP_NTARGETS, 4, number of scratchpad matrix slots
DIM_W, $clog2(MAX_DIM), width of dimension fields and feed index
SP_W, $clog2(SP_NTARGETS), width of scratchpad slot selects

Ports:
clk_i  in  1  clock; all state changes on rising edge
rst_ni  in  1  reset, asynchronous, active-low
start_i  in  1  control-register start bit (level)
dim_n_i  in  DIM_W  rows of A, encoded N-1
dim_k_i  in  DIM_W  cols of A / rows of B, encoded K-1
dim_m_i  in  DIM_W  cols of B, encoded M-1
mode_bias_i  in  1  1 = accumulators preload C from scratchpad
read_target_i  in  SP_W  scratchpad slot used as bias source
write_target_i  in  SP_W  scratchpad slot receiving result
ovf_i  in  1  datapath overflow indication, valid while array_en_o=1
busy_o  out  1  operation in progress
acc_clr_o  out  1  clear all accumulators
acc_load_o  out  1  load accumulators from scratchpad read data
sp_rd_en_o  out  1  scratchpad read strobe
sp_rd_sel_o  out  SP_W  scratchpad read slot
array_en_o  out  1  PE array shift/MAC enable
feed_en_o  out  1  operand injection valid
feed_idx_o  out  DIM_W  k-slice currently injected
sp_we_o  out  1  scratchpad write strobe (whole result matrix)
sp_wr_sel_o  out  SP_W  scratchpad write slot
done_o  out  1  one-cycle completion pulse
start_clr_o  out  1  one-cycle request to clear start bit
ovf_o  out  1  sticky overflow of last operation, valid from done_o onward

Behaviour:
- Reset (async assert, sync release): FSM=IDLE; all outputs 0; config regs, counters, ovf sticky and start_q cleared. Reset mid-operation aborts with no done_o and no sp_we_o.
- Start detection: start_q <= start_i every cycle. Accept when state=IDLE and start_i=1 and start_q=0 (rising edge). Start held high across reset release therefore triggers once. Start high without an edge never retriggers. Edges outside IDLE are ignored.
- On accept: latch dims, mode_bias, both targets into internal regs. Clear ovf sticky. Input changes afterwards are ignored until the next accept.
- Outputs are Moore decodes of registered state and counters. The first non-IDLE cycle is the cycle after the accepting edge.
- States and transitions:
  - IDLE -> CLEAR on accept.
  - CLEAR (1 cycle): if bias, acc_load_o=1, sp_rd_en_o=1, sp_rd_sel_o=read target; else acc_clr_o=1. -> FEED.
  - FEED (K cycles): array_en_o=1, feed_en_o=1, feed_idx_o=0..K-1 incrementing. -> DRAIN after index K-1.
  - DRAIN (N+M-1 cycles): array_en_o=1, feed_en_o=0. -> WRITE when the drain counter reaches N+M-2.
  - WRITE (1 cycle): sp_we_o=1, sp_wr_sel_o=write target. -> DONE.
  - DONE (1 cycle): done_o=1, start_clr_o=1. -> IDLE.
- busy_o=1 in every state except IDLE.
- Select outputs and feed_idx_o are 0 whenever their strobe is low.
- Drain counter width DIM_W+1; N+M-1 is computed from the decoded dims without overflow (max 2*MAX_DIM-1).
- ovf sticky: set on any cycle with array_en_o=1 and ovf_i=1. ovf_i in other states is ignored. Held until the next accept or reset.
- Total cycles, CLEAR through DONE inclusive: K+N+M+2. Example: 4x4x4 -> 14 cycles; 1x1x1 -> 5 cycles.
- Back-to-back: a new edge can be accepted in the first IDLE cycle after DONE (earliest CLEAR is 2 cycles after DONE).

Test Plan:
- Dims enc 3,3,3, bias=0, edge on start_i -> acc_clr_o 1 cycle; feed_en_o 4 cycles with idx 0,1,2,3; array_en_o 11 cycles; sp_we_o once; done_o+start_clr_o in cycle 14; busy_o high cycles 1-14.
- Dims enc 0,0,0, bias=1, read_target=2, write_target=1 -> CLEAR with acc_load_o=1, sp_rd_sel_o=2; FEED 1 cycle; DRAIN 1 cycle; sp_wr_sel_o=1; done_o in cycle 5.
- Change dims and targets to new values during FEED -> schedule and selects reflect the latched values; sp_wr_sel_o equals the value at accept.
- start_i held high through DONE and 10 further cycles -> single operation only. Drop start_i low, raise again -> second operation starts with CLEAR the cycle after the edge.
- Assert rst_ni low in the 3rd FEED cycle -> all outputs 0 immediately (async). No done_o or sp_we_o. After release with start_i low, FSM stays IDLE.
- Pulse ovf_i in DRAIN -> ovf_o=1 at done_o and stays 1 until the next accept. ovf_i pulsed in IDLE -> ovf_o unaffected.
